vector_sequencer: RTL

Command-stream scheduler that sits upstream of the vector beam controller. Buffers move/draw/end-of-frame commands in a local FIFO and issues them one at a time as single-cycle `jump`/`draw` pulses with held `x`/`y` once the controller reports `ready`. Inserts a beam-settle delay after every jump and enforces a minimum frame period, so software or a display-list fetcher can push commands without tracking controller timing.

---
 rtl/vector_pkg.sv | 22 ++
 rtl/vec_cmd_fifo.sv | 54 +++++
 rtl/vector_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// Shared definitions for the vector command sequencer: command field layout,
// opcodes and the sequencer FSM encoding.
package vector_pkg;

  localparam int CMD_W   = 26;
  localparam int COORD_W = 12;

  localparam logic [1:0] OP_MOVE      = 2'b00;
  localparam logic [1:0] OP_DRAW      = 2'b01;
  localparam logic [1:0] OP_END_FRAME = 2'b10;
  localparam logic [1:0] OP_NOP       = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_GUARD      = 3'd2,
    ST_WAIT       = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_FRAME_WAIT = 3'd5
  } vec_state_e;

endpackage

// File: rtl/vec_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head; a push is
// refused while full even if a pop happens in the same cycle.
module vec_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vector_sequencer.sv
// Issues buffered move/draw/end-of-frame commands to the beam controller with
// a post-pulse guard, post-jump beam settle and a minimum frame period.
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int GUARD_CYCLES  = 2,
  parameter int FRAME_CYCLES  = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [CMD_W-1:0]   cmd_data,
  output logic               cmd_ready,
  input  logic               ctrl_ready,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               jump,
  output logic               draw,
  output logic               beam_on,
  output logic               frame_done,
  output logic               busy,
  output vec_state_e         dbg_state_o
);

  localparam int GW = (GUARD_CYCLES > 0)  ? $clog2(GUARD_CYCLES + 1)  : 1;
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int FW = (FRAME_CYCLES > 0)  ? $clog2(FRAME_CYCLES + 1)  : 1;

  // Command handshake: a word is taken on any clock where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on FIFO fullness.
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CMD_W-1:0]   fifo_head;
  logic [1:0]         head_op;

  vec_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (cmd_valid),
    .push_data_i (cmd_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign head_op   = fifo_head[25:24];

  vec_state_e         state_q, state_d;
  logic               is_draw_q, is_draw_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [GW-1:0]      guard_cnt_q, guard_cnt_d;
  logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
  logic [FW-1:0]      frame_cnt_q;
  logic               frame_sat;
  logic               frame_clr;

  assign frame_sat = (frame_cnt_q == FW'(FRAME_CYCLES));

  // ctrl_ready is ignored for GUARD_CYCLES cycles counting the pulse cycle,
  // so GUARD itself lasts GUARD_CYCLES-1 cycles.
  always_comb begin
    state_d      = state_q;
    is_draw_d    = is_draw_q;
    x_d          = x_q;
    y_d          = y_q;
    guard_cnt_d  = guard_cnt_q;
    settle_cnt_d = settle_cnt_q;
    fifo_pop     = 1'b0;
    frame_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          case (head_op)
            OP_NOP: fifo_pop = 1'b1;
            OP_END_FRAME: begin
              fifo_pop = 1'b1;
              state_d  = ST_FRAME_WAIT;
            end
            default: begin
              // The head stays in the FIFO until the controller is ready.
              x_d       = fifo_head[23:12];
              y_d       = fifo_head[11:0];
              is_draw_d = (head_op == OP_DRAW);
              if (ctrl_ready) begin
                fifo_pop = 1'b1;
                state_d  = ST_ISSUE;
              end
            end
          endcase
        end
      end
      ST_ISSUE: begin
        guard_cnt_d = '0;
        state_d     = (GUARD_CYCLES > 1) ? ST_GUARD : ST_WAIT;
      end
      ST_GUARD: begin
        if (int'(guard_cnt_q) >= GUARD_CYCLES - 2) state_d = ST_WAIT;
        else guard_cnt_d = guard_cnt_q + GW'(1);
      end
      ST_WAIT: begin
        if (ctrl_ready) begin
          if (is_draw_q || SETTLE_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (int'(settle_cnt_q) >= SETTLE_CYCLES - 1) state_d = ST_IDLE;
        else settle_cnt_d = settle_cnt_q + SW'(1);
      end
      ST_FRAME_WAIT: begin
        if (frame_sat) begin
          frame_clr = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_draw_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      guard_cnt_q  <= '0;
      settle_cnt_q <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      is_draw_q    <= is_draw_d;
      x_q          <= x_d;
      y_q          <= y_d;
      guard_cnt_q  <= guard_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      if (frame_clr)       frame_cnt_q <= '0;
      else if (!frame_sat) frame_cnt_q <= frame_cnt_q + FW'(1);
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign jump        = (state_q == ST_ISSUE) && !is_draw_q;
  assign draw        = (state_q == ST_ISSUE) && is_draw_q;
  assign beam_on     = is_draw_q && ((state_q == ST_ISSUE) || (state_q == ST_GUARD) ||
                                     (state_q == ST_WAIT));
  assign frame_done  = (state_q == ST_FRAME_WAIT) && frame_sat;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign dbg_state_o = state_q;

endmodule
